// File: rtl/disp_pix_if.sv
// Pixel request bus between the raster timing generator and the pixel source.
// The timing generator (master) publishes the active-area address and a
// request strobe; the source (slave) answers combinationally with a 24-bit
// {R,G,B} pixel in the same cycle.
interface disp_pix_if;
  logic [23:0] disp_data;
  logic [11:0] disp_h_addr;
  logic [11:0] disp_v_addr;
  logic        disp_data_req;

  modport master (
    output disp_h_addr,
    output disp_v_addr,
    output disp_data_req,
    input  disp_data
  );

  modport slave (
    input  disp_h_addr,
    input  disp_v_addr,
    input  disp_data_req,
    output disp_data
  );
endinterface

// File: rtl/disp_timing_ctrl.sv
// Raster timing generator and registered output stage for the RGB/HDMI path.
// Free-running horizontal/vertical counters walk sync, back porch, active and
// front porch regions. The pixel request and address are combinational from
// the counters; HS, VS, DE, RGB and frame_start are registered so that all
// video outputs are aligned one clock after the request.
// Totals (H and V) above 4095 do not fit the 12-bit counters and are illegal.
module disp_timing_ctrl #(
  parameter int H_SYNC   = 128,
  parameter int H_BACK   = 88,
  parameter int H_DISP   = 800,
  parameter int H_FRONT  = 40,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_DISP   = 480,
  parameter int V_FRONT  = 10,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk_disp,
  input  logic        reset,
  disp_pix_if.master  pix,
  output logic        disp_hs,
  output logic        disp_vs,
  output logic        disp_de,
  output logic [7:0]  disp_red,
  output logic [7:0]  disp_green,
  output logic [7:0]  disp_blue,
  output logic        frame_start
);

  // Region boundaries, all in counter width.
  localparam logic [11:0] H_LAST     = 12'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
  localparam logic [11:0] H_START    = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] H_END      = 12'(H_SYNC + H_BACK + H_DISP);
  localparam logic [11:0] H_SYNC_END = 12'(H_SYNC);
  localparam logic [11:0] V_LAST     = 12'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
  localparam logic [11:0] V_START    = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] V_END      = 12'(V_SYNC + V_BACK + V_DISP);
  localparam logic [11:0] V_SYNC_END = 12'(V_SYNC);
  // Pin level while a sync pulse is active; the idle level is its inverse.
  localparam logic        SYNC_ACT   = SYNC_POL;

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;

  logic        h_act_s;
  logic        v_act_s;
  logic        req_s;
  logic        hs_raw_s;
  logic        vs_raw_s;
  logic [11:0] h_addr_s;
  logic [11:0] v_addr_s;

  logic        de_q, de_d;
  logic [23:0] rgb_q, rgb_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        fs_q, fs_d;

  // Next counter values: h wraps at the line end, v steps (and wraps) only there.
  always_comb begin
    h_cnt_d = h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = 12'd0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = 12'd0;
      end else begin
        v_cnt_d = v_cnt_q + 12'd1;
      end
    end else begin
      v_cnt_d = v_cnt_q;
    end
  end

  // Region decode, pixel request and active-area address (0 outside active).
  always_comb begin
    h_act_s  = (h_cnt_q >= H_START) && (h_cnt_q < H_END);
    v_act_s  = (v_cnt_q >= V_START) && (v_cnt_q < V_END);
    req_s    = h_act_s && v_act_s;
    hs_raw_s = (h_cnt_q < H_SYNC_END);
    vs_raw_s = (v_cnt_q < V_SYNC_END);
    h_addr_s = 12'd0;
    v_addr_s = 12'd0;
    if (req_s) begin
      h_addr_s = h_cnt_q - H_START;
      v_addr_s = v_cnt_q - V_START;
    end else begin
      h_addr_s = 12'd0;
      v_addr_s = 12'd0;
    end
  end

  // Next output-stage values; pixel data is discarded outside the active area.
  always_comb begin
    de_d  = req_s;
    rgb_d = 24'h000000;
    if (req_s) begin
      rgb_d = pix.disp_data;
    end else begin
      rgb_d = 24'h000000;
    end
    hs_d = hs_raw_s ~^ SYNC_ACT;
    vs_d = vs_raw_s ~^ SYNC_ACT;
    fs_d = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
  end

  // Raster counters; reset aborts the current frame and restarts at (0,0).
  always_ff @(posedge clk_disp) begin
    if (reset) begin
      h_cnt_q <= 12'd0;
      v_cnt_q <= 12'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Registered video outputs, one clock behind the request; syncs idle in reset.
  always_ff @(posedge clk_disp) begin
    if (reset) begin
      de_q  <= 1'b0;
      rgb_q <= 24'h000000;
      hs_q  <= ~SYNC_ACT;
      vs_q  <= ~SYNC_ACT;
      fs_q  <= 1'b0;
    end else begin
      de_q  <= de_d;
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      fs_q  <= fs_d;
    end
  end

  assign pix.disp_h_addr   = h_addr_s;
  assign pix.disp_v_addr   = v_addr_s;
  assign pix.disp_data_req = req_s;

  assign disp_hs     = hs_q;
  assign disp_vs     = vs_q;
  assign disp_de     = de_q;
  assign disp_red    = rgb_q[23:16];
  assign disp_green  = rgb_q[15:8];
  assign disp_blue   = rgb_q[7:0];
  assign frame_start = fs_q;

endmodule

// File: tb/tb_disp_timing_ctrl.sv
// Directed bench for disp_timing_ctrl: one instance with the default 800x480
// timing (active-low syncs) and one tiny instance with active-high syncs.
// Outputs are sampled on the falling clock edge; sample k is taken after the
// k-th rising edge with reset low, so the counters then hold k mod H_TOTAL
// (line k / H_TOTAL) and the registered outputs describe counter value k-1.
module tb_disp_timing_ctrl;

  logic clk;
  logic rst_a;
  logic rst_b;

  int n_checks;
  int n_errors;

  disp_pix_if pa ();
  disp_pix_if pb ();

  logic       a_hs, a_vs, a_de, a_fs;
  logic [7:0] a_r, a_g, a_b;
  logic       b_hs, b_vs, b_de, b_fs;
  logic [7:0] b_r, b_g, b_b;

  // Pixel source: address-coded pattern, driven regardless of the request.
  function automatic logic [23:0] pix_model(input int h, input int v);
    logic [11:0] hh;
    logic [11:0] vv;
    hh = 12'(h);
    vv = 12'(v);
    return {hh, vv} ^ 24'h5A5A5A;
  endfunction

  assign pa.disp_data = {pa.disp_h_addr, pa.disp_v_addr} ^ 24'h5A5A5A;
  assign pb.disp_data = {pb.disp_h_addr, pb.disp_v_addr} ^ 24'h5A5A5A;

  disp_timing_ctrl u_dut_a (
    .clk_disp    (clk),
    .reset       (rst_a),
    .pix         (pa.master),
    .disp_hs     (a_hs),
    .disp_vs     (a_vs),
    .disp_de     (a_de),
    .disp_red    (a_r),
    .disp_green  (a_g),
    .disp_blue   (a_b),
    .frame_start (a_fs)
  );

  disp_timing_ctrl #(
    .H_SYNC(2), .H_BACK(2), .H_DISP(4), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_DISP(3), .V_FRONT(1),
    .SYNC_POL(1'b1)
  ) u_dut_b (
    .clk_disp    (clk),
    .reset       (rst_b),
    .pix         (pb.master),
    .disp_hs     (b_hs),
    .disp_vs     (b_vs),
    .disp_de     (b_de),
    .disp_red    (b_r),
    .disp_green  (b_g),
    .disp_blue   (b_b),
    .frame_start (b_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  int fs_cnt, hs_low, vs_low, de_cnt, de_first, de_last;
  int hs_hi, vs_hi, de_rise, hs_rise, fs_first, fs_second;
  logic prev_de, prev_hs;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (4) @(negedge clk);

    // Reset state of both instances.
    check_value("a_rst_de",  32'(a_de), 32'd0);
    check_value("a_rst_rgb", 32'({a_r, a_g, a_b}), 32'd0);
    check_value("a_rst_hs",  32'(a_hs), 32'd1);
    check_value("a_rst_vs",  32'(a_vs), 32'd1);
    check_value("a_rst_fs",  32'(a_fs), 32'd0);
    check_value("a_rst_req", 32'(pa.disp_data_req), 32'd0);
    check_value("b_rst_hs",  32'(b_hs), 32'd0);
    check_value("b_rst_vs",  32'(b_vs), 32'd0);

    // Default timing: first 36+ lines of a frame.
    fs_cnt = 0; hs_low = 0; vs_low = 0; de_cnt = 0; de_first = 0; de_last = 0;
    rst_a = 1'b0;
    for (int k = 1; k <= 38516; k++) begin
      @(negedge clk);
      if (a_fs) fs_cnt++;
      if (k <= 1056 && !a_hs) hs_low++;
      if (!a_vs) vs_low++;
      if (a_de && k < 38000) begin
        de_cnt++;
        de_last = k;
        if (de_first == 0) de_first = k;
      end
      if (k == 1) begin
        check_value("a_fs_first", 32'(a_fs), 32'd1);
        check_value("a_hs_start", 32'(a_hs), 32'd0);
      end
      if (k == 129) check_value("a_hs_end", 32'(a_hs), 32'd1);
      if (k == 37175) check_value("a_rgb_blank", 32'({a_r, a_g, a_b}), 32'd0);
      if (k == 37176) begin
        check_value("a_req_first", 32'(pa.disp_data_req), 32'd1);
        check_value("a_haddr_0",   32'(pa.disp_h_addr), 32'd0);
        check_value("a_vaddr_0",   32'(pa.disp_v_addr), 32'd0);
      end
      if (k == 37177) check_value("a_pix_0_0", 32'({a_r, a_g, a_b}), 32'(pix_model(0, 0)));
      if (k == 37576) check_value("a_haddr_400", 32'(pa.disp_h_addr), 32'd400);
      if (k == 37577) check_value("a_pix_400_0", 32'({a_r, a_g, a_b}), 32'(pix_model(400, 0)));
      if (k == 37975) check_value("a_haddr_799", 32'(pa.disp_h_addr), 32'd799);
      if (k == 37976) check_value("a_pix_799_0", 32'({a_r, a_g, a_b}), 32'(pix_model(799, 0)));
      if (k == 37977) begin
        check_value("a_req_after", 32'(pa.disp_data_req), 32'd0);
        check_value("a_haddr_out", 32'(pa.disp_h_addr), 32'd0);
      end
    end
    check_value("a_fs_count", 32'(fs_cnt), 32'd1);
    check_value("a_hs_width", 32'(hs_low), 32'd128);
    check_value("a_vs_width", 32'(vs_low), 32'd2112);
    check_value("a_de_first", 32'(de_first), 32'd37177);
    check_value("a_de_last",  32'(de_last), 32'd37976);
    check_value("a_de_count", 32'(de_cnt), 32'd800);
    // Counters now at h=500, v=36: DE is high, then reset mid-frame.
    check_value("a_de_pre_rst", 32'(a_de), 32'd1);
    rst_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_value("a_mid_rst_de",  32'(a_de), 32'd0);
      check_value("a_mid_rst_rgb", 32'({a_r, a_g, a_b}), 32'd0);
      check_value("a_mid_rst_hs",  32'(a_hs), 32'd1);
      check_value("a_mid_rst_vs",  32'(a_vs), 32'd1);
      check_value("a_mid_rst_fs",  32'(a_fs), 32'd0);
    end
    rst_a = 1'b0;
    @(negedge clk);
    check_value("a_post_rst_fs", 32'(a_fs), 32'd1);
    check_value("a_post_rst_hs", 32'(a_hs), 32'd0);
    @(negedge clk);
    check_value("a_post_rst_fs_off", 32'(a_fs), 32'd0);

    // Tiny timing, active-high syncs: 10-clock lines, 60-clock frames.
    hs_hi = 0; vs_hi = 0; de_cnt = 0; de_rise = 0; hs_rise = 0;
    fs_cnt = 0; fs_first = 0; fs_second = 0;
    prev_de = 1'b0; prev_hs = 1'b0;
    rst_b = 1'b0;
    for (int k = 1; k <= 130; k++) begin
      @(negedge clk);
      if (b_fs) begin
        fs_cnt++;
        if (fs_cnt == 1) fs_first = k;
        if (fs_cnt == 2) fs_second = k;
      end
      if (k <= 60) begin
        if (b_hs) hs_hi++;
        if (b_vs) vs_hi++;
        if (b_de) de_cnt++;
        if (b_de && !prev_de) de_rise++;
        if (b_hs && !prev_hs) hs_rise++;
      end
      prev_de = b_de;
      prev_hs = b_hs;
      if (k == 47) begin
        check_value("b_req_last",   32'(pb.disp_data_req), 32'd1);
        check_value("b_haddr_last", 32'(pb.disp_h_addr), 32'd3);
        check_value("b_vaddr_last", 32'(pb.disp_v_addr), 32'd2);
      end
      if (k == 48) check_value("b_pix_3_2", 32'({b_r, b_g, b_b}), 32'(pix_model(3, 2)));
      if (k == 60) check_value("b_de_wrap0", 32'(b_de), 32'd0);
      if (k == 61) check_value("b_de_wrap1", 32'(b_de), 32'd0);
    end
    check_value("b_fs_first",  32'(fs_first), 32'd1);
    check_value("b_fs_period", 32'(fs_second - fs_first), 32'd60);
    check_value("b_fs_count",  32'(fs_cnt), 32'd3);
    check_value("b_hs_high",   32'(hs_hi), 32'd12);
    check_value("b_hs_lines",  32'(hs_rise), 32'd6);
    check_value("b_vs_high",   32'(vs_hi), 32'd10);
    check_value("b_de_count",  32'(de_cnt), 32'd12);
    check_value("b_de_rises",  32'(de_rise), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
